// File: rtl/latch_output_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : latch_output_monitor_pkg
// Description : Shared FSM state encodings and synchronizer reset values for
//               the latch output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package latch_output_monitor_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_STABLE  = 2'd1,
    ST_INVALID = 2'd2,
    ST_UNUSED  = 2'd3
  } state_e;

  // Reset values of the synchronized pair: a legal "latch holds 0" pair
  localparam logic Q_RST_VAL    = 1'b0;
  localparam logic NOTQ_RST_VAL = 1'b1;

  // A latch pair is meaningful only when the two outputs are complementary
  function automatic logic pair_is_good(input logic q, input logic notq);
    return q ^ notq;
  endfunction

endpackage
`default_nettype wire

// File: rtl/latch_output_monitor_bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : bit_synchronizer
// Description : Multi-flop synchronizer for one asynchronous bit, with a
//               configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage deeper each clock
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain registers, restored to the reset value on rst
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/latch_output_monitor.sv
`default_nettype none
// ============================================================================
// Module      : latch_output_monitor
// Description : Synchronizes a D latch's Q/notQ pair, filters glitches,
//               checks complementarity and publishes a qualified level,
//               edge pulses, a saturating edge count and a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module latch_output_monitor
  import latch_output_monitor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Q,
  input  logic             notQ,
  input  logic             clr_cnt,
  output logic             q_out,
  output logic             valid,
  output logic             rise,
  output logic             fall,
  output logic             invalid_err,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [1:0]       state
);

  localparam int              FC_W   = $clog2(FILTER_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILTER_CYCLES);

  logic q_s;
  logic notq_s;

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(Q_RST_VAL)) u_sync_q (
    .clk (clk),
    .rst (rst),
    .d   (Q),
    .q   (q_s)
  );

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(NOTQ_RST_VAL)) u_sync_notq (
    .clk (clk),
    .rst (rst),
    .d   (notQ),
    .q   (notq_s)
  );

  logic [1:0]       pair;
  logic             good;
  logic             bad_hit;
  logic             settle_hit;

  logic [1:0]       prev_pair_q,   prev_pair_d;
  logic [FC_W-1:0]  settle_cnt_q,  settle_cnt_d;
  logic [FC_W-1:0]  bad_cnt_q,     bad_cnt_d;
  state_e           state_q,       state_d;
  logic             q_out_q,       q_out_d;
  logic             valid_q,       valid_d;
  logic             rise_q,        rise_d;
  logic             fall_q,        fall_d;
  logic             err_q,         err_d;
  logic [CNT_W-1:0] edge_cnt_q,    edge_cnt_d;

  assign pair = {q_s, notq_s};
  assign good = pair_is_good(q_s, notq_s);

  // Stability and bad-run counters; both saturate at FILTER_CYCLES
  always_comb begin
    prev_pair_d  = pair;
    settle_cnt_d = '0;
    bad_cnt_d    = '0;
    if (good) begin
      if (pair == prev_pair_q) begin
        settle_cnt_d = (settle_cnt_q == FC_MAX) ? settle_cnt_q : settle_cnt_q + FC_W'(1);
      end else begin
        settle_cnt_d = FC_W'(1);
      end
    end else begin
      bad_cnt_d = (bad_cnt_q == FC_MAX) ? bad_cnt_q : bad_cnt_q + FC_W'(1);
    end
  end

  // Decisions use the next counter values so the outputs register on the
  // same edge at which a count reaches FILTER_CYCLES. A bad run only fires
  // once on arrival, so clr_cnt can clear the error while the run persists.
  assign settle_hit = (settle_cnt_d == FC_MAX);
  assign bad_hit    = (bad_cnt_d == FC_MAX) && (bad_cnt_q != FC_MAX);

  // Next-state and registered-output logic for the qualification FSM
  always_comb begin
    state_d = state_q;
    q_out_d = q_out_q;
    valid_d = valid_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (bad_hit) begin
      state_d = ST_INVALID;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_hit) begin
            q_out_d = q_s;
            valid_d = 1'b1;
            rise_d  = q_s & ~q_out_q;
            fall_d  = ~q_s & q_out_q;
            state_d = ST_STABLE;
          end
        end
        ST_STABLE: begin
          if (good && (q_s != q_out_q)) begin
            state_d = ST_SETTLE;
          end
        end
        ST_INVALID: begin
          if (good) begin
            state_d = ST_SETTLE;
          end
        end
        default: begin
          state_d = ST_SETTLE;
        end
      endcase
    end
  end

  // Sticky error (a new set beats clr_cnt) and saturating edge counter
  // (clr_cnt beats a coincident edge)
  always_comb begin
    err_d = err_q;
    if (bad_hit) begin
      err_d = 1'b1;
    end else if (clr_cnt) begin
      err_d = 1'b0;
    end
    edge_cnt_d = edge_cnt_q;
    if (clr_cnt) begin
      edge_cnt_d = '0;
    end else if ((rise_q | fall_q) && !(&edge_cnt_q)) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // All monitor state, restored together on rst
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pair_q  <= {Q_RST_VAL, NOTQ_RST_VAL};
      settle_cnt_q <= '0;
      bad_cnt_q    <= '0;
      state_q      <= ST_SETTLE;
      q_out_q      <= 1'b0;
      valid_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      err_q        <= 1'b0;
      edge_cnt_q   <= '0;
    end else begin
      prev_pair_q  <= prev_pair_d;
      settle_cnt_q <= settle_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      state_q      <= state_d;
      q_out_q      <= q_out_d;
      valid_q      <= valid_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      err_q        <= err_d;
      edge_cnt_q   <= edge_cnt_d;
    end
  end

  assign q_out       = q_out_q;
  assign valid       = valid_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign invalid_err = err_q;
  assign edge_cnt    = edge_cnt_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_latch_output_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_latch_output_monitor
// Description : Directed, table-driven bench for latch_output_monitor with
//               default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_output_monitor;

  logic       clk;
  logic       rst;
  logic       Q;
  logic       notQ;
  logic       clr_cnt;
  logic       q_out;
  logic       valid;
  logic       rise;
  logic       fall;
  logic       invalid_err;
  logic [7:0] edge_cnt;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  latch_output_monitor #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Q           (Q),
    .notQ        (notQ),
    .clr_cnt     (clr_cnt),
    .q_out       (q_out),
    .valid       (valid),
    .rise        (rise),
    .fall        (fall),
    .invalid_err (invalid_err),
    .edge_cnt    (edge_cnt),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       q;
    logic       nq;
    logic       clr;
    int         hold;
    logic       e_qout;
    logic       e_valid;
    logic       e_err;
    logic [1:0] e_state;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt [10];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic q, input logic nq);
    Q    = q;
    notQ = nq;
  endtask

  initial begin
    //            q     nq    clr   hold qout  valid err   state cnt
    vt[0] = '{1'b0, 1'b1, 1'b0, 8,  1'b0, 1'b1, 1'b0, 2'd1, 8'd2}; // fall after first rise
    vt[1] = '{1'b1, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0, 2'd0, 8'd2}; // short pulse seen
    vt[2] = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 2'd1, 8'd2}; // pulse filtered
    vt[3] = '{1'b1, 1'b1, 1'b0, 6,  1'b0, 1'b0, 1'b1, 2'd2, 8'd2}; // 11 for 4 samples
    vt[4] = '{1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 2'd0, 8'd2}; // requalifying
    vt[5] = '{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 2'd1, 8'd2}; // 6th cycle: valid
    vt[6] = '{1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0, 2'd1, 8'd0}; // clr_cnt
    vt[7] = '{1'b1, 1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0, 2'd1, 8'd0}; // short bad run
    vt[8] = '{1'b0, 1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b0, 2'd1, 8'd0}; // bad run tail
    vt[9] = '{1'b0, 1'b1, 1'b0, 6,  1'b0, 1'b1, 1'b0, 2'd1, 8'd0}; // stays STABLE

    // Reset with the latch holding 1
    rst     = 1'b1;
    clr_cnt = 1'b0;
    drive(1'b1, 1'b0);
    tick(3);
    chk("rst q_out", q_out, 0);
    chk("rst valid", valid, 0);
    chk("rst rise", rise, 0);
    chk("rst fall", fall, 0);
    chk("rst invalid_err", invalid_err, 0);
    chk("rst edge_cnt", edge_cnt, 0);
    chk("rst state", state, 0);

    // Qualification latency after release
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk($sformatf("t1 c%0d q_out", k), q_out, 0);
      chk($sformatf("t1 c%0d valid", k), valid, 0);
      chk($sformatf("t1 c%0d rise", k), rise, 0);
    end
    tick(1);
    chk("t1 c6 q_out", q_out, 1);
    chk("t1 c6 valid", valid, 1);
    chk("t1 c6 rise", rise, 1);
    chk("t1 c6 state", state, 1);
    tick(1);
    chk("t1 c7 rise", rise, 0);
    chk("t1 c7 edge_cnt", edge_cnt, 1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].q, vt[i].nq);
      clr_cnt = vt[i].clr;
      tick(vt[i].hold);
      chk($sformatf("vec%0d q_out", i), q_out, vt[i].e_qout);
      chk($sformatf("vec%0d valid", i), valid, vt[i].e_valid);
      chk($sformatf("vec%0d invalid_err", i), invalid_err, vt[i].e_err);
      chk($sformatf("vec%0d state", i), state, vt[i].e_state);
      chk($sformatf("vec%0d edge_cnt", i), edge_cnt, vt[i].e_cnt);
    end
    clr_cnt = 1'b0;

    // Error set coinciding with clr_cnt: set wins
    drive(1'b1, 1'b1);
    tick(5);
    clr_cnt = 1'b1;
    tick(1);
    chk("setclr invalid_err", invalid_err, 1);
    chk("setclr state", state, 2);
    chk("setclr valid", valid, 0);
    tick(1);
    chk("clr during bad run invalid_err", invalid_err, 0);
    clr_cnt = 1'b0;
    drive(1'b0, 1'b1);
    tick(8);
    chk("recover state", state, 1);
    chk("recover valid", valid, 1);
    chk("recover invalid_err", invalid_err, 0);

    // Edge counter saturation over 300 toggles
    for (int i = 0; i < 300; i++) begin
      drive((i % 2) == 0, (i % 2) != 0);
      tick(8);
      if (i == 9) chk("sat cnt after 10", edge_cnt, 10);
      if (i == 255) chk("sat cnt after 256", edge_cnt, 255);
    end
    chk("sat cnt after 300", edge_cnt, 255);
    chk("sat q_out", q_out, 0);

    // clr_cnt in the same cycle as a rise pulse
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    chk("clr edge_cnt", edge_cnt, 0);
    drive(1'b1, 1'b0);
    tick(6);
    chk("clrrise rise", rise, 1);
    clr_cnt = 1'b1;
    tick(1);
    chk("clrrise edge_cnt", edge_cnt, 0);
    clr_cnt = 1'b0;
    tick(1);
    chk("clrrise edge_cnt after", edge_cnt, 0);
    chk("clrrise rise after", rise, 0);

    // Fall pulse and count before the mid-operation reset
    drive(1'b0, 1'b1);
    tick(6);
    chk("fall pulse", fall, 1);
    chk("fall q_out", q_out, 0);
    tick(1);
    chk("fall pulse end", fall, 0);
    chk("fall edge_cnt", edge_cnt, 1);
    drive(1'b1, 1'b0);
    tick(8);
    chk("pre-rst edge_cnt", edge_cnt, 2);

    // Reset while settle_cnt is 2, then full requalification
    drive(1'b0, 1'b1);
    tick(4);
    rst = 1'b1;
    drive(1'b1, 1'b0);
    tick(1);
    chk("midrst q_out", q_out, 0);
    chk("midrst valid", valid, 0);
    chk("midrst state", state, 0);
    chk("midrst edge_cnt", edge_cnt, 0);
    chk("midrst invalid_err", invalid_err, 0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk($sformatf("t6 c%0d valid", k), valid, 0);
      chk($sformatf("t6 c%0d q_out", k), q_out, 0);
    end
    tick(1);
    chk("t6 c6 q_out", q_out, 1);
    chk("t6 c6 valid", valid, 1);
    chk("t6 c6 rise", rise, 1);
    chk("t6 c6 state", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
